// File: rtl/sandpiper_7seg_driver_if.sv
// Signal bundle between the char-to-segment upstream logic and the
// Sandpiper 7-segment driver, including the four 74HC595-side pins.
interface sandpiper_7seg_driver_if;
  logic       en;
  logic       clear_buffer;
  logic       commit_char;
  logic [7:0] SEGMENTS_2_LIGHT;
  logic [2:0] CHAR_SELECTED;
  logic [7:0] CHAR_BRIGHTNESS;
  logic       SCLK;
  logic       DOUT;
  logic       RCLK;
  logic       OE;

  // Upstream side: owns the buffer writes, enable and brightness,
  // and sees the shift-register pins.
  modport master (
    output en,
    output clear_buffer,
    output commit_char,
    output SEGMENTS_2_LIGHT,
    output CHAR_SELECTED,
    output CHAR_BRIGHTNESS,
    input  SCLK,
    input  DOUT,
    input  RCLK,
    input  OE
  );

  // Driver side.
  modport slave (
    input  en,
    input  clear_buffer,
    input  commit_char,
    input  SEGMENTS_2_LIGHT,
    input  CHAR_SELECTED,
    input  CHAR_BRIGHTNESS,
    output SCLK,
    output DOUT,
    output RCLK,
    output OE
  );
endinterface

// File: rtl/sandpiper_7seg_driver.sv
// Multiplexed 8-digit 7-segment driver for the Sandpiper board.
// An 8-entry segment buffer is scanned one digit per refresh tick through
// two cascaded 74HC595 shift registers. Each frame is {anode, seg}, shifted
// MSB first, then latched with an RCLK pulse. Brightness is a free-running
// 8-bit PWM on the active-low OE pin.
module sandpiper_7seg_driver #(
  parameter int SYSCLK_F = 24000000,
  parameter int SCLK_F   = 1000000,
  parameter int DIGIT_HZ = 1000,
  parameter int CHAR_CT  = 8
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  sandpiper_7seg_driver_if.slave bus
);

  // Half-period of SCLK in sys_clk cycles, never below one cycle.
  localparam int HALF_RAW     = SYSCLK_F / (2 * SCLK_F);
  localparam int HALF         = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int HCW          = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DIGIT_PERIOD = SYSCLK_F / DIGIT_HZ;
  localparam int TCW          = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

  localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(DIGIT_PERIOD - 1);
  localparam logic [2:0]     DIGIT_MAX = 3'(CHAR_CT - 1);

  // A frame lasts 1 + 32*HALF + HALF cycles; DIGIT_PERIOD must exceed that
  // or ticks arriving outside IDLE are silently skipped.

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [TCW-1:0]   tickCnt_q;
  logic [7:0]       pwmCnt_q;
  logic [7:0]       buffer_q [CHAR_CT];
  logic [2:0]       digit_q, digit_d;
  logic [15:0]      shift_q, shift_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [HCW-1:0]   halfCnt_q, halfCnt_d;
  logic             sclk_q, sclk_d;
  logic             dout_q, dout_d;
  logic             rclk_q, rclk_d;

  logic             digitTick;
  logic             halfDone;
  logic [7:0]       anode;
  logic [15:0]      frame;
  logic             pwmOn;

  assign digitTick = (tickCnt_q == TICK_LAST);
  assign halfDone  = (halfCnt_q == HALF_LAST);
  assign anode     = 8'd1 << digit_q;
  assign frame     = {anode, buffer_q[digit_q]};

  // Free-running refresh divider and PWM counter, independent of the FSM.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tickCnt_q <= '0;
      pwmCnt_q  <= '0;
    end else begin
      tickCnt_q <= digitTick ? '0 : tickCnt_q + 1'b1;
      pwmCnt_q  <= pwmCnt_q + 8'd1;
    end
  end

  // Segment buffer: clear beats commit; writes land regardless of en and
  // only become visible at the next LOAD because the frame is a snapshot.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHAR_CT; i++) begin
        buffer_q[i] <= '0;
      end
    end else if (bus.clear_buffer) begin
      for (int i = 0; i < CHAR_CT; i++) begin
        buffer_q[i] <= '0;
      end
    end else if (bus.commit_char) begin
      buffer_q[bus.CHAR_SELECTED] <= bus.SEGMENTS_2_LIGHT;
    end
  end

  // Scan FSM state and datapath registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      digit_q   <= '0;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      halfCnt_q <= '0;
      sclk_q    <= 1'b0;
      dout_q    <= 1'b0;
      rclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      halfCnt_q <= halfCnt_d;
      sclk_q    <= sclk_d;
      dout_q    <= dout_d;
      rclk_q    <= rclk_d;
    end
  end

  // Next-state logic: DOUT changes only while SCLK is low so the 595 sees
  // a full half-period of setup before each rising edge; en is only looked
  // at in IDLE so a frame in flight always reaches its latch.
  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    shift_d   = shift_q;
    bitCnt_d  = bitCnt_q;
    halfCnt_d = halfCnt_q;
    sclk_d    = sclk_q;
    dout_d    = dout_q;
    rclk_d    = rclk_q;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        rclk_d = 1'b0;
        if (digitTick && bus.en) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        shift_d   = frame;
        dout_d    = frame[15];
        bitCnt_d  = '0;
        halfCnt_d = '0;
        sclk_d    = 1'b0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        if (!halfDone) begin
          halfCnt_d = halfCnt_q + 1'b1;
        end else begin
          halfCnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bitCnt_q == 4'd15) begin
              rclk_d  = 1'b1;
              state_d = LATCH;
            end else begin
              bitCnt_d = bitCnt_q + 4'd1;
              shift_d  = {shift_q[14:0], 1'b0};
              dout_d   = shift_q[14];
            end
          end
        end
      end

      LATCH: begin
        if (!halfDone) begin
          halfCnt_d = halfCnt_q + 1'b1;
        end else begin
          halfCnt_d = '0;
          rclk_d    = 1'b0;
          digit_d   = (digit_q == DIGIT_MAX) ? 3'd0 : digit_q + 3'd1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // OE is combinational so dropping en blanks the display at once; reset is
  // folded in because the PWM compare alone could enable the outputs while
  // rst is held with en high.
  assign pwmOn = (bus.CHAR_BRIGHTNESS == 8'hFF) || (pwmCnt_q < bus.CHAR_BRIGHTNESS);

  assign bus.OE   = rst | ~(bus.en & pwmOn);
  assign bus.SCLK = sclk_q;
  assign bus.DOUT = dout_q;
  assign bus.RCLK = rclk_q;

endmodule

// File: tb/tb_sandpiper_7seg_driver.sv
// Bench for sandpiper_7seg_driver. A short digit period (240 cycles, HALF=3)
// keeps many full scans inside a small cycle count. Expected frames come from
// a buffer/digit model driven by the refresh-tick arithmetic; a monitor
// decodes the SCLK/DOUT/RCLK pins and compares against the queue.
`timescale 1ns/1ps
module tb_sandpiper_7seg_driver;

  localparam int SYSCLK_F = 24000000;
  localparam int SCLK_F   = 4000000;
  localparam int DIGIT_HZ = 100000;
  localparam int HALF     = SYSCLK_F / (2 * SCLK_F);
  localparam int PERIOD   = SYSCLK_F / DIGIT_HZ;

  typedef struct {
    logic [15:0] frame;
    int          start;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst;

  sandpiper_7seg_driver_if bus();

  sandpiper_7seg_driver #(
    .SYSCLK_F (SYSCLK_F),
    .SCLK_F   (SCLK_F),
    .DIGIT_HZ (DIGIT_HZ),
    .CHAR_CT  (8)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int         compared   = 0;
  int         mismatched = 0;
  int         cycNum     = 0;
  int         digitM     = 0;
  logic [7:0] bufM [8];
  exp_t       expQ [$];

  task automatic checkOutput(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic commit, input logic clear,
                               input logic [7:0] seg, input logic [2:0] sel);
    @(posedge sys_clk); #2;
    bus.commit_char      = commit;
    bus.clear_buffer     = clear;
    bus.SEGMENTS_2_LIGHT = seg;
    bus.CHAR_SELECTED    = sel;
    @(posedge sys_clk); #2;
    bus.commit_char      = 1'b0;
    bus.clear_buffer     = 1'b0;
    bus.SEGMENTS_2_LIGHT = 8'($urandom);
    bus.CHAR_SELECTED    = 3'($urandom);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic waitSclkHigh();
    int found = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge sys_clk);
      if (bus.SCLK === 1'b1) begin
        found = 1;
        break;
      end
    end
    checkOutput("sclk_activity_seen", found, 1);
  endtask

  // Reference model: buffer contents and scan position; a frame is expected
  // on every refresh tick that finds en high, carrying the buffer as it
  // stands after that edge's write.
  initial begin
    forever begin
      @(posedge sys_clk or posedge rst);
      if (rst) begin
        cycNum = 0;
        digitM = 0;
        for (int i = 0; i < 8; i++) bufM[i] = 8'h00;
        expQ.delete();
      end else begin
        cycNum++;
        if (bus.clear_buffer) begin
          for (int i = 0; i < 8; i++) bufM[i] = 8'h00;
        end else if (bus.commit_char) begin
          bufM[bus.CHAR_SELECTED] = bus.SEGMENTS_2_LIGHT;
        end
        if ((cycNum % PERIOD) == 0 && bus.en) begin
          exp_t e;
          e.frame = {8'(1 << digitM), bufM[digitM]};
          e.start = cycNum;
          expQ.push_back(e);
          digitM = (digitM + 1) % 8;
        end
      end
    end
  end

  // Pin monitor: decodes frames, checks timing and the OE duty rule.
  initial begin
    logic        prevS = 1'b0;
    logic        prevR = 1'b0;
    logic [15:0] shiftM = '0;
    int          bits = 0;
    int          lastRise = 0;
    int          rclkRise = 0;
    int          rclkSeen = 0;
    int          oeExp;
    exp_t        e;
    forever begin
      @(negedge sys_clk);
      if (rst) begin
        checkOutput("oe_in_reset", int'(bus.OE), 1);
        prevS = 1'b0; prevR = 1'b0; bits = 0; rclkSeen = 0; shiftM = '0;
      end else begin
        oeExp = (bus.en && (bus.CHAR_BRIGHTNESS == 8'hFF ||
                 (cycNum % 256) < int'(bus.CHAR_BRIGHTNESS))) ? 0 : 1;
        checkOutput("oe_pwm", int'(bus.OE), oeExp);

        if (!prevS && bus.SCLK) begin
          checkOutput("sclk_expected", int'(expQ.size() != 0), 1);
          if (expQ.size() != 0) begin
            if (bits == 0) checkOutput("first_sclk_time", cycNum, expQ[0].start + 1 + HALF);
            else           checkOutput("sclk_period", cycNum - lastRise, 2 * HALF);
          end
          lastRise = cycNum;
          shiftM   = {shiftM[14:0], bus.DOUT};
          bits++;
        end

        if (!prevR && bus.RCLK) begin
          if (expQ.size() == 0) begin
            checkOutput("rclk_expected", 0, 1);
          end else begin
            e = expQ.pop_front();
            checkOutput("frame_bits", bits, 16);
            checkOutput("frame_data", int'(shiftM), int'(e.frame));
            checkOutput("latch_time", cycNum, e.start + 1 + 32 * HALF);
          end
          rclkRise = cycNum;
          rclkSeen = 1;
          bits     = 0;
        end

        if (prevR && !bus.RCLK && rclkSeen != 0) begin
          checkOutput("rclk_width", cycNum - rclkRise, HALF);
        end

        prevS = bus.SCLK;
        prevR = bus.RCLK;
      end
    end
  end

  // Directed scenarios followed by randomized writes and brightness changes.
  initial begin
    int         r;
    logic [7:0] b;
    rst                  = 1'b1;
    bus.en               = 1'b1;
    bus.clear_buffer     = 1'b0;
    bus.commit_char      = 1'b0;
    bus.SEGMENTS_2_LIGHT = 8'h00;
    bus.CHAR_SELECTED    = 3'd0;
    bus.CHAR_BRIGHTNESS  = 8'hFF;

    repeat (3) @(posedge sys_clk);
    #3;
    checkOutput("reset_sclk", int'(bus.SCLK), 0);
    checkOutput("reset_rclk", int'(bus.RCLK), 0);
    checkOutput("reset_dout", int'(bus.DOUT), 0);
    checkOutput("reset_oe", int'(bus.OE), 1);
    @(posedge sys_clk); #2;
    rst = 1'b0;
    bus.CHAR_BRIGHTNESS = 8'h40;

    $display("[TB] digit 2 = 0x3F, full scan order");
    applyStimulus(1'b1, 1'b0, 8'h3F, 3'd2);
    waitCycles(10 * PERIOD);

    $display("[TB] brightness extremes");
    bus.CHAR_BRIGHTNESS = 8'hFF;
    waitCycles(300);
    bus.CHAR_BRIGHTNESS = 8'h00;
    waitCycles(300);
    bus.CHAR_BRIGHTNESS = 8'h40;

    $display("[TB] commit and clear on the same edge");
    applyStimulus(1'b1, 1'b1, 8'h06, 3'd3);
    waitCycles(9 * PERIOD);

    $display("[TB] randomized writes");
    for (int i = 0; i < 40; i++) begin
      waitCycles($urandom_range(1, 100));
      r = $urandom_range(0, 99);
      if (r < 70) begin
        applyStimulus(1'b1, 1'b0, 8'($urandom), 3'($urandom));
      end else if (r < 75) begin
        applyStimulus(1'b0, 1'b1, 8'($urandom), 3'($urandom));
      end else if (r < 80) begin
        applyStimulus(1'b1, 1'b1, 8'($urandom), 3'($urandom));
      end else begin
        r = $urandom_range(0, 2);
        b = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
        bus.CHAR_BRIGHTNESS = b;
      end
    end
    waitCycles(PERIOD);

    $display("[TB] en dropped mid-frame");
    waitSclkHigh();
    @(posedge sys_clk); #2;
    bus.en = 1'b0;
    waitCycles(3 * PERIOD);
    bus.en = 1'b1;
    waitCycles(3 * PERIOD);

    $display("[TB] reset mid-shift");
    waitSclkHigh();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midreset_sclk", int'(bus.SCLK), 0);
    checkOutput("midreset_rclk", int'(bus.RCLK), 0);
    checkOutput("midreset_dout", int'(bus.DOUT), 0);
    checkOutput("midreset_oe", int'(bus.OE), 1);
    repeat (2) @(posedge sys_clk);
    #2;
    rst = 1'b0;
    waitCycles(3 * PERIOD);

    bus.en = 1'b0;
    waitCycles(2 * PERIOD);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
